spike_event_recorder: RTL and testbench

SPIKE_EVENT_RECORDER -- requirements
Module: spike_event_recorder

---
 rtl/spike_event_recorder.sv | 155 +++++++++++++++
 tb/tb_spike_event_recorder.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_event_recorder.sv
// Spike event recorder: per-column pending slots, round-robin arbiter and a timestamped event FIFO.
// Optional lost-event counter enabled by defining SPIKE_RECORDER_DROP_CNT_EN.
module spike_event_recorder #(
    parameter int NUM_COLS   = 1,
    parameter int FIFO_DEPTH = 8,
    parameter int TS_WIDTH   = 16,
    localparam int CW = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1,
    localparam int AW = $clog2(FIFO_DEPTH),
    localparam int LW = AW + 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_COLS-1:0] spike_valid,
    input  logic [NUM_COLS-1:0] spike_on_off,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CW-1:0]       out_col,
    output logic                out_on_off,
    output logic [TS_WIDTH-1:0] out_ts,
    output logic [LW-1:0]       fifo_level,
    output logic [15:0]         drop_count
);

    logic [TS_WIDTH-1:0] ts;
    logic [NUM_COLS-1:0] pend;
    logic [NUM_COLS-1:0] pend_pol;
    logic [TS_WIDTH-1:0] pend_ts [NUM_COLS];

    logic [CW-1:0]       rr_ptr;
    logic [CW-1:0]       grant_idx;
    logic                grant_any;
    logic [NUM_COLS-1:0] grant_vec;

    logic [CW-1:0]         mem_col [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] mem_pol;
    logic [TS_WIDTH-1:0]   mem_ts  [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [LW-1:0]         level;

    logic full;
    logic pop;
    logic space;

    assign full      = (level == LW'(FIFO_DEPTH));
    assign out_valid = (level != '0);
    assign pop       = out_valid && out_ready;
    assign space     = !full || pop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ts <= '0;
        else          ts <= ts + 1'b1;
    end

    // Rotating search starting at rr_ptr; first pending slot wins
    always_comb begin
        int unsigned idx;
        logic [CW-1:0] cidx;
        grant_any = 1'b0;
        grant_idx = '0;
        grant_vec = '0;
        idx       = 0;
        cidx      = '0;
        for (int unsigned off = 0; off < NUM_COLS; off++) begin
            idx = 32'(rr_ptr) + off;
            if (idx >= NUM_COLS) idx = idx - NUM_COLS;
            cidx = CW'(idx);
            if (!grant_any && space && pend[cidx]) begin
                grant_any = 1'b1;
                grant_idx = cidx;
            end
        end
        if (grant_any) grant_vec[grant_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr <= '0;
        end else if (grant_any) begin
            rr_ptr <= (grant_idx == CW'(NUM_COLS - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend     <= '0;
            pend_pol <= '0;
            for (int unsigned i = 0; i < NUM_COLS; i++) pend_ts[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_COLS; i++) begin
                if (spike_valid[i] && (!pend[i] || grant_vec[i])) begin
                    pend[i]     <= 1'b1;
                    pend_pol[i] <= spike_on_off[i];
                    pend_ts[i]  <= ts;
                end else if (grant_vec[i]) begin
                    pend[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (grant_any) begin
            mem_col[wr_ptr] <= grant_idx;
            mem_pol[wr_ptr] <= pend_pol[grant_idx];
            mem_ts[wr_ptr]  <= pend_ts[grant_idx];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (grant_any) wr_ptr <= wr_ptr + 1'b1;
            if (pop)       rd_ptr <= rd_ptr + 1'b1;
            if (grant_any && !pop)      level <= level + 1'b1;
            else if (!grant_any && pop) level <= level - 1'b1;
        end
    end

    // Head fields forced to zero while empty so unwritten storage never leaks out
    assign out_col    = out_valid ? mem_col[rd_ptr] : '0;
    assign out_on_off = out_valid ? mem_pol[rd_ptr] : 1'b0;
    assign out_ts     = out_valid ? mem_ts[rd_ptr]  : '0;
    assign fifo_level = level;

`ifdef SPIKE_RECORDER_DROP_CNT_EN
    logic [NUM_COLS-1:0] drop_vec;
    logic [15:0]         drop_next;
    logic [15:0]         drop_cnt;

    assign drop_vec = spike_valid & pend & ~grant_vec;

    always_comb begin
        int unsigned n;
        int unsigned sum;
        n = 0;
        for (int unsigned i = 0; i < NUM_COLS; i++) n = n + 32'(drop_vec[i]);
        sum       = 32'(drop_cnt) + n;
        drop_next = (sum > 32'hFFFF) ? 16'hFFFF : sum[15:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) drop_cnt <= '0;
        else          drop_cnt <= drop_next;
    end

    assign drop_count = drop_cnt;
`else
    assign drop_count = '0;
`endif

endmodule

// File: tb/tb_spike_event_recorder.sv
// Self-checking bench for spike_event_recorder: directed scenarios plus random traffic vs a queue model.
module tb_spike_event_recorder;
    localparam int N  = 4;
    localparam int D  = 8;
    localparam int TW = 6;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [N-1:0]  spike_valid;
    logic [N-1:0]  spike_on_off;
    logic          out_valid;
    logic          out_ready;
    logic [1:0]    out_col;
    logic          out_on_off;
    logic [TW-1:0] out_ts;
    logic [3:0]    fifo_level;
    logic [15:0]   drop_count;

    always #5 clk = ~clk;

    spike_event_recorder #(
        .NUM_COLS  (N),
        .FIFO_DEPTH(D),
        .TS_WIDTH  (TW)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .spike_valid (spike_valid),
        .spike_on_off(spike_on_off),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_col     (out_col),
        .out_on_off  (out_on_off),
        .out_ts      (out_ts),
        .fifo_level  (fifo_level),
        .drop_count  (drop_count)
    );

    typedef struct {
        int col;
        int pol;
        int ts;
    } ev_t;

    ev_t q[$];
    int  m_ts, m_rr, m_drops;
    bit  m_pend [N];
    int  m_pol  [N];
    int  m_pts  [N];
    bit  fresh;
    int  n_assert = 0;
    int  n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ts = 0; m_rr = 0; m_drops = 0; fresh = 1'b1;
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 1'b0; m_pol[i] = 0; m_pts[i] = 0;
        end
    endtask

    task automatic model_edge();
        bit  pop;
        int  g;
        ev_t e;
        if (!reset_n) begin
            model_reset();
            return;
        end
        pop = (q.size() > 0) && out_ready;
        g = -1;
        if (q.size() < D || pop) begin
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (m_rr + k) % N;
                if (g < 0 && m_pend[idx]) g = idx;
            end
        end
        if (pop) q.delete(0);
        if (g >= 0) begin
            e.col = g; e.pol = m_pol[g]; e.ts = m_pts[g];
            q.push_back(e);
            m_pend[g] = 1'b0;
            m_rr = (g + 1) % N;
            fresh = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            if (spike_valid[i]) begin
                if (!m_pend[i]) begin
                    m_pend[i] = 1'b1; m_pol[i] = int'(spike_on_off[i]); m_pts[i] = m_ts;
                end else if (m_drops < 65535) begin
                    m_drops++;
                end
            end
        end
        m_ts = (m_ts + 1) % (1 << TW);
    endtask

    task automatic check_outputs();
        int exp_drop;
`ifdef SPIKE_RECORDER_DROP_CNT_EN
        exp_drop = m_drops;
`else
        exp_drop = 0;
`endif
        chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
        chk("fifo_level", 32'(fifo_level), 32'(q.size()));
        chk("drop_count", 32'(drop_count), 32'(exp_drop));
        if (q.size() > 0) begin
            chk("out_col", 32'(out_col), 32'(q[0].col));
            chk("out_on_off", 32'(out_on_off), 32'(q[0].pol));
            chk("out_ts", 32'(out_ts), 32'(q[0].ts));
        end else if (fresh) begin
            chk("out_col_rst", 32'(out_col), 32'd0);
            chk("out_on_off_rst", 32'(out_on_off), 32'd0);
            chk("out_ts_rst", 32'(out_ts), 32'd0);
        end
    endtask

    task automatic tick();
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic wait_ts(input int t);
        for (int g = 0; g < 200 && m_ts != t; g++) tick();
        chk("wait_ts", 32'(m_ts), 32'(t));
    endtask

    initial begin
        int prev_ts;
        reset_n = 1'b0; spike_valid = '0; spike_on_off = '0; out_ready = 1'b0;
        model_reset();
        #2;
        repeat (3) tick();
        chk("reset_valid", 32'(out_valid), 32'd0);
        chk("reset_level", 32'(fifo_level), 32'd0);
        reset_n = 1'b1;

        // all four columns at ts=10 leave in column order
        out_ready = 1'b1;
        wait_ts(10);
        spike_valid = 4'hF; spike_on_off = 4'($urandom);
        tick();
        spike_valid = '0;
        tick();
        for (int k = 0; k < 4; k++) begin
            chk("all_col", 32'(out_col), 32'(k));
            chk("all_ts", 32'(out_ts), 32'd10);
            tick();
        end
        chk("all_empty", 32'(fifo_level), 32'd0);

        // single spike latency at ts=5
        wait_ts(5);
        spike_valid = 4'b0001; spike_on_off = 4'b0001;
        tick();
        spike_valid = '0;
        tick();
        chk("lat_valid", 32'(out_valid), 32'd1);
        chk("lat_col", 32'(out_col), 32'd0);
        chk("lat_pol", 32'(out_on_off), 32'd1);
        chk("lat_ts", 32'(out_ts), 32'd5);
        tick();
        chk("lat_level", 32'(fifo_level), 32'd0);

        // fill FIFO, hold ninth pending, drop tenth
        out_ready = 1'b0;
        wait_ts(20);
        for (int k = 0; k < 10; k++) begin
            spike_valid = 4'b0001; spike_on_off = 4'($urandom);
            tick();
            spike_valid = '0;
            tick();
        end
        chk("full_level", 32'(fifo_level), 32'd8);
`ifdef SPIKE_RECORDER_DROP_CNT_EN
        chk("full_drop", 32'(drop_count), 32'd1);
`else
        chk("full_drop", 32'(drop_count), 32'd0);
`endif

        // drain: nine entries with increasing timestamps
        out_ready = 1'b1;
        prev_ts = -1;
        for (int k = 0; k < 9; k++) begin
            chk("drain_valid", 32'(out_valid), 32'd1);
            chk("drain_incr", 32'(int'(out_ts) > prev_ts), 32'd1);
            prev_ts = int'(out_ts);
            tick();
        end
        chk("drain_level", 32'(fifo_level), 32'd0);

        // timestamp wrap
        out_ready = 1'b0;
        wait_ts(62);
        spike_valid = 4'b0100; spike_on_off = 4'b0100;
        tick();
        spike_valid = '0;
        wait_ts(1);
        spike_valid = 4'b0100; spike_on_off = 4'b0000;
        tick();
        spike_valid = '0;
        tick();
        tick();
        out_ready = 1'b1;
        chk("wrap_ts0", 32'(out_ts), 32'd62);
        tick();
        chk("wrap_ts1", 32'(out_ts), 32'd1);
        tick();

        // random traffic, light then heavy backpressure
        for (int k = 0; k < 600; k++) begin
            spike_valid  = 4'($urandom) & 4'($urandom);
            spike_on_off = 4'($urandom);
            out_ready    = (k < 300) ? ($urandom_range(3) != 0) : ($urandom_range(3) == 0);
            tick();
        end

        // asynchronous reset with three stored entries and one pending
        spike_valid = '0; out_ready = 1'b1;
        repeat (15) tick();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            spike_valid = 4'b0010; spike_on_off = 4'($urandom);
            tick();
            spike_valid = '0;
            tick();
        end
        spike_valid = 4'b1000;
        tick();
        spike_valid = '0;
        chk("pre_rst_level", 32'(fifo_level), 32'd3);
        reset_n = 1'b0;
        #1;
        chk("rst_async_valid", 32'(out_valid), 32'd0);
        chk("rst_async_level", 32'(fifo_level), 32'd0);
        model_reset();
        repeat (2) tick();
        reset_n = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("post_rst_valid", 32'(out_valid), 32'd0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
